ast_byte_packer: RTL

Avalon-ST byte-to-word packer that sits directly upstream of the 64→128 width converter. It accepts a packetised stream of 8-bit symbols, with sop, eop and channel, and packs them big-endian into DATA_W-bit words with empty, sop, eop and channel. Its output feeds the converter's sink port unchanged. One output register provides full symbol throughput under backpressure.

---
 rtl/ast_byte_packer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ast_byte_packer.sv
// Avalon-ST packer: collects a packetised 8-bit symbol stream big-endian into
// DATA_W-bit words carrying sop/eop/empty/channel, behind one output register.
module ast_byte_packer #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = ($clog2(DATA_W/8) ? $clog2(DATA_W/8) : 1),
  parameter int CHANNEL_W = 10
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [7:0]           snk_data_i,
  input  logic                 snk_startofpacket_i,
  input  logic                 snk_endofpacket_i,
  input  logic                 snk_valid_i,
  input  logic [CHANNEL_W-1:0] snk_channel_i,
  output logic                 snk_ready_o,
  output logic [DATA_W-1:0]    src_data_o,
  output logic                 src_startofpacket_o,
  output logic                 src_endofpacket_o,
  output logic                 src_valid_o,
  output logic [EMPTY_W-1:0]   src_empty_o,
  output logic [CHANNEL_W-1:0] src_channel_o,
  input  logic                 src_ready_i,
  output logic                 err_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [EMPTY_W-1:0] LAST_IDX = EMPTY_W'(NB - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [EMPTY_W-1:0]   cnt_r, cnt_nxt_s, idx_s;
  logic                 first_word_r, first_word_nxt_s;
  logic [CHANNEL_W-1:0] chan_r, chan_nxt_s;
  logic [DATA_W-1:0]    acc_r, acc_nxt_s, base_s, word_s;
  logic                 sym_acc_s, pack_s, err_s, load_s, load_sop_s;
  logic [CHANNEL_W-1:0] load_chan_s;
  logic [EMPTY_W-1:0]   load_empty_s;

  logic                 out_valid_r, out_sop_r, out_eop_r, err_r;
  logic [DATA_W-1:0]    out_data_r;
  logic [EMPTY_W-1:0]   out_empty_r;
  logic [CHANNEL_W-1:0] out_chan_r;

  assign snk_ready_o = ~out_valid_r | src_ready_i;
  assign sym_acc_s   = snk_valid_i & snk_ready_o;
  // A sop always starts a word; a non-sop symbol is only packed inside a packet.
  assign pack_s      = sym_acc_s & (snk_startofpacket_i | (state_r == IN_PKT));
  assign err_s       = sym_acc_s & (snk_startofpacket_i ? (state_r == IN_PKT) : (state_r == IDLE));

  // Next-state, accumulator update and output-register load decode.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    first_word_nxt_s = first_word_r;
    chan_nxt_s       = chan_r;
    acc_nxt_s        = acc_r;
    idx_s            = cnt_r;
    base_s           = acc_r;
    word_s           = acc_r;
    load_s           = 1'b0;
    load_sop_s       = first_word_r;
    load_chan_s      = chan_r;
    load_empty_s     = '0;
    if (pack_s) begin
      if (snk_startofpacket_i) begin
        idx_s            = '0;
        chan_nxt_s       = snk_channel_i;
        load_chan_s      = snk_channel_i;
        load_sop_s       = 1'b1;
        first_word_nxt_s = 1'b1;
      end else begin
        idx_s = cnt_r;
      end
      // Starting a fresh word clears stale bytes so unused low bytes load as 0.
      base_s = (idx_s == '0) ? '0 : acc_r;
      for (int b = 0; b < NB; b++) begin
        word_s[DATA_W-1-8*b -: 8] = (idx_s == EMPTY_W'(b)) ? snk_data_i : base_s[DATA_W-1-8*b -: 8];
      end
      acc_nxt_s = word_s;
      if ((idx_s == LAST_IDX) || snk_endofpacket_i) begin
        load_s           = 1'b1;
        cnt_nxt_s        = '0;
        first_word_nxt_s = 1'b0;
        load_empty_s     = snk_endofpacket_i ? (LAST_IDX - idx_s) : '0;
        state_nxt_s      = snk_endofpacket_i ? IDLE : IN_PKT;
      end else begin
        cnt_nxt_s   = idx_s + EMPTY_W'(1);
        state_nxt_s = IN_PKT;
      end
    end else begin
      idx_s = cnt_r;
    end
  end

  // Packet state, byte counter, latched channel and partial word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      first_word_r <= 1'b0;
      chan_r       <= '0;
      acc_r        <= '0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      first_word_r <= first_word_nxt_s;
      chan_r       <= chan_nxt_s;
      acc_r        <= acc_nxt_s;
    end
  end

  // Output word register and registered error pulse.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_empty_r <= '0;
      out_chan_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= err_s;
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= word_s;
        out_sop_r   <= load_sop_s;
        out_eop_r   <= snk_endofpacket_i;
        out_empty_r <= load_empty_s;
        out_chan_r  <= load_chan_s;
      end else if (src_ready_i) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign src_valid_o         = out_valid_r;
  assign src_data_o          = out_data_r;
  assign src_startofpacket_o = out_sop_r;
  assign src_endofpacket_o   = out_eop_r;
  assign src_empty_o         = out_empty_r;
  assign src_channel_o       = out_chan_r;
  assign err_o               = err_r;

endmodule
